adc_axil_regbank: RTL

//  Parametrised AXI4-Lite slave register bank for the ADC controller.
//  - RW control registers, read-only per-channel latest-sample registers, one status register.
//  - Status register has sticky overflow flags, cleared by writing 1 (W1C).
//  - Supports byte write strobes. Returns SLVERR for addresses outside the register map.
//  - Sits between the PS AXI interconnect and the ADC capture front-end.

---
 rtl/adc_axil_regbank.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_axil_regbank.sv
// adc_axil_regbank: AXI4-Lite register bank for the ADC controller.
// Ports: s_axi_* AXI4-Lite slave, adc_valid/adc_data capture in, ctrl_regs flat out.
module adc_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CTRL_REGS      = 4,
  parameter int NUM_CH             = 2,
  parameter int ADC_WIDTH          = 14
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [NUM_CH-1:0]               adc_valid,
  input  logic [NUM_CH*ADC_WIDTH-1:0]     adc_data,
  output logic [NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int IW   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int SW   = DW / 8;
  localparam int STAT = NUM_CTRL_REGS + NUM_CH;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  wstate_t wstate;
  wstate_t wstate_nx;

  logic [DW-1:0]        ctrl [NUM_CTRL_REGS];
  logic [ADC_WIDTH-1:0] sample [NUM_CH];
  logic [NUM_CH-1:0]    new_f;
  logic [NUM_CH-1:0]    ovf_f;
  logic [NUM_CH-1:0]    rd_clr;
  logic [NUM_CH-1:0]    ovf_clr;

  logic          aw_done;
  logic          w_done;
  logic [IW-1:0] widx;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          w_commit;
  logic          w_ok;
  logic          r_ok;
  logic          cap_en;
  logic [IW-1:0] ridx;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] stat_word;
  logic          unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ready lines are held low while reset is asserted
  assign s_axi_awready = s_axi_aresetn && (wstate == W_IDLE) && !aw_done;
  assign s_axi_wready  = s_axi_aresetn && (wstate == W_IDLE) && !w_done;
  assign s_axi_arready = s_axi_aresetn && !s_axi_rvalid;

  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign w_hs     = s_axi_wvalid && s_axi_wready;
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign w_commit = (wstate == W_IDLE) && aw_done && w_done;
  assign ridx     = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ok     = int'(widx) <= STAT;
  assign r_ok     = int'(ridx) <= STAT;
  assign cap_en   = ctrl[0][0];

  for (genvar i = 0; i < NUM_CTRL_REGS; i++) begin : g_ctrl_out
    assign ctrl_regs[i*DW +: DW] = ctrl[i];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wstate <= W_IDLE;
    end else begin
      wstate <= wstate_nx;
    end
  end

  always_comb begin
    wstate_nx = wstate;
    unique case (wstate)
      W_IDLE: if (w_commit) wstate_nx = W_RESP;
      W_RESP: if (s_axi_bready) wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      widx    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
        widx    <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_done  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (w_commit) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else if (w_commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= w_ok ? 2'b00 : 2'b10;
    end else if (s_axi_bvalid && s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_CTRL_REGS; i++) ctrl[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL_REGS; i++) begin
        if (w_commit && int'(widx) == i) begin
          for (int b = 0; b < SW; b++) begin
            if (wstrb_q[b]) ctrl[i][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_clr  = '0;
    ovf_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_clr[c]  = ar_hs && int'(ridx) == NUM_CTRL_REGS + c;
      ovf_clr[c] = w_commit && int'(widx) == STAT &&
                   wdata_q[16+c] && wstrb_q[(16+c)/8];
    end
  end

  // capture beats read-clear of new and W1C of ovf
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int c = 0; c < NUM_CH; c++) sample[c] <= '0;
      new_f <= '0;
      ovf_f <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_en && adc_valid[c]) begin
          sample[c] <= adc_data[c*ADC_WIDTH +: ADC_WIDTH];
          new_f[c]  <= 1'b1;
          if (new_f[c]) ovf_f[c] <= 1'b1;
          else if (ovf_clr[c]) ovf_f[c] <= 1'b0;
        end else begin
          if (rd_clr[c]) new_f[c] <= 1'b0;
          if (ovf_clr[c]) ovf_f[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    stat_word = '0;
    stat_word[NUM_CH-1:0] = new_f;
    stat_word[16 +: NUM_CH] = ovf_f;
    rd_word = '0;
    for (int i = 0; i < NUM_CTRL_REGS; i++) begin
      if (int'(ridx) == i) rd_word = ctrl[i];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ridx) == NUM_CTRL_REGS + c) rd_word[ADC_WIDTH-1:0] = sample[c];
    end
    if (int'(ridx) == STAT) rd_word = stat_word;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= r_ok ? 2'b00 : 2'b10;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule
